// File: rtl/io_responder_pkg.sv
`timescale 1ns/1ps
// io_responder shared definitions:
// IO map, read offsets and the select helper.
package io_responder_pkg;

  localparam logic [31:0] IO_UART     = 32'h0003_0000;
  localparam logic [31:0] IO_CLK      = 32'h0003_0004;
  localparam logic [31:0] IO_SEL_MASK = 32'h0003_0000;

  typedef enum logic [2:0] {
    OFF_UART = 3'd0,
    OFF_CLK0 = 3'd4,
    OFF_CLK1 = 3'd5,
    OFF_CLK2 = 3'd6,
    OFF_CLK3 = 3'd7
  } io_off_e;

  function automatic logic io_hit(
    input logic        rdy,
    input logic [17:0] a
  );
    return rdy &
      ((a & IO_SEL_MASK[17:0]) == IO_SEL_MASK[17:0]);
  endfunction

endpackage

// File: rtl/io_responder_if.sv
`timescale 1ns/1ps
// CPU bus, UART TX/RX handshakes and status
// flags of io_responder.
interface io_responder_if;

  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  io_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_finish;
  logic        tx_overflow;

  modport master (
    output rdy_in, mem_a, mem_wr, mem_dout,
    output tx_ready, rx_data, rx_valid,
    input  io_din, io_buffer_full,
    input  tx_data, tx_valid, rx_pop,
    input  program_finish, tx_overflow
  );

  modport slave (
    input  rdy_in, mem_a, mem_wr, mem_dout,
    input  tx_ready, rx_data, rx_valid,
    output io_din, io_buffer_full,
    output tx_data, tx_valid, rx_pop,
    output program_finish, tx_overflow
  );

endinterface

// File: rtl/io_responder_fifo.sv
`timescale 1ns/1ps
// io_fifo: byte queue toward the UART.
// Storage is not reset; pointers wrap naturally.
module io_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // a pop from full only frees the slot next cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + (AW+1)'(do_push)
                   - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/io_responder.sv
`timescale 1ns/1ps
// io_responder: memory-mapped UART/clock IO
// with TX queue, cycle counter and snapshot.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16
) (
  input logic           clk_in,
  input logic           rst_in,
  io_responder_if.slave bus
);

  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    din_q, din_d;
  logic          fin_q, fin_d;
  logic          ovf_q, ovf_d;
  logic          sel, rd, wr;
  logic [2:0]    off;
  logic          uart_wr, clk_wr, push;
  logic [7:0]    push_data;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          unused_a;

  assign unused_a  = ^bus.mem_a[31:18];
  assign sel       = io_hit(bus.rdy_in, bus.mem_a[17:0]);
  assign off       = bus.mem_a[2:0];
  assign rd        = sel & ~bus.mem_wr;
  assign wr        = sel & bus.mem_wr & ~fin_q;
  assign uart_wr   = wr & (off == IO_UART[2:0])
                   & (bus.mem_dout != 8'h00);
  assign clk_wr    = wr & (off == IO_CLK[2:0]);
  assign push      = uart_wr | clk_wr;
  assign push_data = clk_wr ? 8'h00 : bus.mem_dout;

  io_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (bus.tx_ready),
    .dout_o  (bus.tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    din_d      = 8'h00;
    snap_d     = snap_q;
    cnt_d      = cnt_q + 32'd1;
    fin_d      = fin_q | clk_wr;
    ovf_d      = ovf_q | (uart_wr & fifo_full);
    bus.rx_pop = 1'b0;
    unique case (1'b1)
      (rd && off == OFF_UART): begin
        bus.rx_pop = bus.rx_valid;
        din_d = bus.rx_valid ? bus.rx_data : 8'h00;
      end
      (rd && off == OFF_CLK0): begin
        din_d  = cnt_q[7:0];
        snap_d = cnt_q;
      end
      (rd && off == OFF_CLK1): din_d = snap_q[15:8];
      (rd && off == OFF_CLK2): din_d = snap_q[23:16];
      (rd && off == OFF_CLK3): din_d = snap_q[31:24];
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      snap_q <= '0;
      din_q  <= '0;
      fin_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      din_q  <= din_d;
      fin_q  <= fin_d;
      ovf_q  <= ovf_d;
    end
  end

  // head-room of two covers the one-cycle write latency
  assign bus.io_buffer_full = (fifo_cnt >= CW'(TX_DEPTH - 2));
  assign bus.io_din         = din_q;
  assign bus.tx_valid       = ~fifo_empty;
  assign bus.program_finish = fin_q;
  assign bus.tx_overflow    = ovf_q;

endmodule

// File: tb/tb_io_responder.sv
`timescale 1ns/1ps
// Directed scoreboard bench for io_responder:
// read data and TX bytes checked against queues.
module tb_io_responder;
  import io_responder_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic        m_fin;
  logic        m_ovf;

  io_responder_if bus();

  io_responder #(
    .TX_DEPTH (DEPTH)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) m_cnt <= 32'd0;
    else     m_cnt <= m_cnt + 32'd1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.rdy_in   = 1'b0;
    bus.mem_a    = 32'h0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
  endtask

  task automatic cyc(input logic        rdy,
                     input logic [31:0] a,
                     input logic        wr,
                     input logic [7:0]  d);
    logic       hit;
    logic [7:0] exp_din;
    logic       exp_pop;
    logic       full;
    logic       pop;
    @(negedge clk);
    bus.rdy_in   = rdy;
    bus.mem_a    = a;
    bus.mem_wr   = wr;
    bus.mem_dout = d;
    hit     = rdy && (a[17:16] == 2'b11);
    exp_din = 8'h00;
    exp_pop = 1'b0;
    if (hit && !wr) begin
      case (a[2:0])
        3'd0: begin
          exp_pop = bus.rx_valid;
          exp_din = bus.rx_valid ? bus.rx_data : 8'h00;
        end
        3'd4: begin
          exp_din = m_cnt[7:0];
          m_snap  = m_cnt;
        end
        3'd5: exp_din = m_snap[15:8];
        3'd6: exp_din = m_snap[23:16];
        3'd7: exp_din = m_snap[31:24];
        default: ;
      endcase
    end
    rd_q.push_back(exp_din);
    full = (tx_q.size() == DEPTH);
    pop  = (tx_q.size() != 0) && bus.tx_ready;
    #1;
    chk("rx_pop", 32'(bus.rx_pop), 32'(exp_pop));
    chk("tx_valid", 32'(bus.tx_valid),
        32'(tx_q.size() != 0));
    chk("buf_full", 32'(bus.io_buffer_full),
        32'(tx_q.size() >= DEPTH - 2));
    if (pop)
      chk("tx_data", 32'(bus.tx_data),
          32'(tx_q.pop_front()));
    if (hit && wr && !m_fin) begin
      if (a[2:0] == 3'd0 && d != 8'h00) begin
        if (full) m_ovf = 1'b1;
        else      tx_q.push_back(d);
      end else if (a[2:0] == 3'd4) begin
        if (!full) tx_q.push_back(8'h00);
        m_fin = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("io_din", 32'(bus.io_din), 32'(rd_q.pop_front()));
    chk("finish", 32'(bus.program_finish), 32'(m_fin));
    chk("overflow", 32'(bus.tx_overflow), 32'(m_ovf));
  endtask

  task automatic wr_b(input logic [31:0] a,
                      input logic [7:0] d);
    cyc(1'b1, a, 1'b1, d);
  endtask

  task automatic rd_b(input logic [31:0] a);
    cyc(1'b1, a, 1'b0, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_io_din", 32'(bus.io_din), 32'd0);
    chk("rst_finish", 32'(bus.program_finish), 32'd0);
    chk("rst_overflow", 32'(bus.tx_overflow), 32'd0);
    chk("rst_buf_full", 32'(bus.io_buffer_full), 32'd0);
    tx_q.delete();
    rd_q.delete();
    m_fin  = 1'b0;
    m_ovf  = 1'b0;
    m_snap = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_tx_valid", 32'(bus.tx_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #2;
    apply_reset();

    // zero bytes are filtered, push+pop overlap
    bus.tx_ready = 1'b1;
    wr_b(IO_UART, 8'h41);
    wr_b(IO_UART, 8'h00);
    wr_b(IO_UART, 8'h42);
    repeat (3) idle();

    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    rd_b(IO_UART);
    bus.rx_valid = 1'b0;
    rd_b(IO_UART);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hC3;
    cyc(1'b0, IO_UART, 1'b0, 8'h00);
    rd_b(32'h0003_0001);
    rd_b(32'h0002_0000);
    rd_b(32'hABC7_0000);
    bus.rx_valid = 1'b0;
    wr_b(32'h0003_0002, 8'h77);

    // fill to full, overflow, full+pop edge
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      wr_b(IO_UART, 8'(i + 16));
    wr_b(IO_UART, 8'hEE);
    bus.tx_ready = 1'b1;
    wr_b(IO_UART, 8'hEF);
    repeat (18) idle();

    for (int i = 0; i < 400 && m_cnt < 32'd300; i++)
      idle();
    rd_b(IO_CLK);
    rd_b(32'h0003_0005);
    rd_b(32'h0003_0006);
    rd_b(32'h0003_0007);
    repeat (3) idle();
    cyc(1'b0, IO_CLK, 1'b0, 8'h00);
    rd_b(32'h0003_0005);
    rd_b(IO_CLK);
    rd_b(32'h0003_0005);

    // reset with bytes queued and io_din nonzero
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      wr_b(IO_UART, 8'(i + 8'h61));
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    rd_b(IO_UART);
    bus.rx_valid = 1'b0;
    #2;
    apply_reset();
    bus.tx_ready = 1'b1;
    repeat (3) idle();

    bus.tx_ready = 1'b0;
    wr_b(IO_CLK, 8'h99);
    wr_b(IO_UART, 8'h43);
    wr_b(IO_CLK, 8'h01);
    bus.tx_ready = 1'b1;
    repeat (3) idle();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h3C;
    rd_b(IO_UART);
    bus.rx_valid = 1'b0;
    rd_b(IO_CLK);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
